// File: rtl/tile_loop_controller.sv
// Tile loop controller: walks the output-block grid of one input-depth slice,
// fetching one input tile per block and launching the PE array on it.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   data_prepare_i      level start request; also gates DONE -> IDLE
//   block_width_i/height_i, data_id_i, size_type_i
//                       pass configuration, latched on start
//   fetch_req_o/gnt_i   tile fetch handshake; tile_x/y/id/size_o describe the tile
//   pe_start_o/done_i   PE launch pulse and completion
//   loop_finished_o     one-cycle pulse when the last block is done
//   busy_o              high whenever not IDLE
//   stall_cnt_o         stall cycle counter (build with TILE_PERF_CNT_EN),
//                       otherwise tied to 0
module tile_loop_controller #(
    parameter int BLK_W   = 8,
    parameter int ID_W    = 4,
    parameter int COORD_W = 11,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               data_prepare_i,
    input  logic [BLK_W-1:0]   block_width_i,
    input  logic [BLK_W-1:0]   block_height_i,
    input  logic [ID_W-1:0]    data_id_i,
    input  logic               size_type_i,
    output logic               fetch_req_o,
    input  logic               fetch_gnt_i,
    output logic [COORD_W-1:0] tile_x_o,
    output logic [COORD_W-1:0] tile_y_o,
    output logic [ID_W-1:0]    tile_id_o,
    output logic [3:0]         tile_size_o,
    output logic               pe_start_o,
    input  logic               pe_done_i,
    output logic               loop_finished_o,
    output logic               busy_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        NEXT,
        DONE
    } state_t;

    state_t             state;
    logic [BLK_W-1:0]   col;
    logic [BLK_W-1:0]   row;
    logic [BLK_W-1:0]   col_last;
    logic [BLK_W-1:0]   row_last;
    logic               small_q;

    logic               row_end;
    logic               last_blk;
    logic [BLK_W-1:0]   col_nx;
    logic [BLK_W-1:0]   row_nx;
    logic [COORD_W-1:0] stride;
    logic [COORD_W-1:0] x_nx;
    logic [COORD_W-1:0] y_nx;

    // Raster order, column fastest; next position precomputed so the
    // registered coordinates are valid in the first LOAD cycle.
    assign row_end  = (col == col_last);
    assign last_blk = row_end && (row == row_last);
    assign col_nx   = row_end ? '0 : col + 1'b1;
    assign row_nx   = row_end ? row + 1'b1 : row;
    assign stride   = small_q ? COORD_W'(4) : COORD_W'(6);
    assign x_nx     = COORD_W'(col_nx) * stride;
    assign y_nx     = COORD_W'(row_nx) * stride;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            col             <= '0;
            row             <= '0;
            col_last        <= '0;
            row_last        <= '0;
            small_q         <= 1'b0;
            fetch_req_o     <= 1'b0;
            tile_x_o        <= '0;
            tile_y_o        <= '0;
            tile_id_o       <= '0;
            tile_size_o     <= '0;
            pe_start_o      <= 1'b0;
            loop_finished_o <= 1'b0;
            busy_o          <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (data_prepare_i) begin
                        state       <= LOAD;
                        busy_o      <= 1'b1;
                        fetch_req_o <= 1'b1;
                        col         <= '0;
                        row         <= '0;
                        // A zero block count still means one block.
                        col_last    <= (block_width_i == '0) ?
                                       '0 : block_width_i - 1'b1;
                        row_last    <= (block_height_i == '0) ?
                                       '0 : block_height_i - 1'b1;
                        small_q     <= size_type_i;
                        tile_x_o    <= '0;
                        tile_y_o    <= '0;
                        tile_id_o   <= data_id_i;
                        tile_size_o <= size_type_i ? 4'd6 : 4'd8;
                    end
                end
                LOAD: begin
                    if (fetch_gnt_i) begin
                        state       <= COMPUTE;
                        fetch_req_o <= 1'b0;
                        pe_start_o  <= 1'b1;
                    end
                end
                COMPUTE: begin
                    pe_start_o <= 1'b0;
                    // done in the launch cycle belongs to the previous tile
                    if (pe_done_i && !pe_start_o) begin
                        state           <= NEXT;
                        loop_finished_o <= last_blk;
                    end
                end
                NEXT: begin
                    loop_finished_o <= 1'b0;
                    if (last_blk) begin
                        state <= DONE;
                    end else begin
                        state       <= LOAD;
                        fetch_req_o <= 1'b1;
                        col         <= col_nx;
                        row         <= row_nx;
                        tile_x_o    <= x_nx;
                        tile_y_o    <= y_nx;
                    end
                end
                DONE: begin
                    if (!data_prepare_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TILE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic             stall_now;

    assign stall_now = ((state == LOAD) && !fetch_gnt_i) ||
                       ((state == COMPUTE) && !pe_start_o && !pe_done_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if ((state == IDLE) && data_prepare_i) begin
            stall_q <= '0;
        end else if (stall_now && (stall_q != '1)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tile_loop_controller.sv
// Testbench for tile_loop_controller: table of pass configurations, tile
// scoreboard, plus hand-written DONE-hold and mid-pass reset sequences.
module tb_tile_loop_controller;

    localparam int BLK_W   = 8;
    localparam int ID_W    = 4;
    localparam int COORD_W = 11;
    localparam int CNT_W   = 16;

    logic               clk = 1'b0;
    logic               reset_n = 1'b1;
    logic               data_prepare = 1'b0;
    logic [BLK_W-1:0]   block_width = '0;
    logic [BLK_W-1:0]   block_height = '0;
    logic [ID_W-1:0]    data_id = '0;
    logic               size_type = 1'b0;
    logic               fetch_req;
    logic               fetch_gnt = 1'b0;
    logic [COORD_W-1:0] tile_x;
    logic [COORD_W-1:0] tile_y;
    logic [ID_W-1:0]    tile_id;
    logic [3:0]         tile_size;
    logic               pe_start;
    logic               pe_done = 1'b0;
    logic               loop_finished;
    logic               busy;
    logic [CNT_W-1:0]   stall_cnt;

    tile_loop_controller #(
        .BLK_W(BLK_W), .ID_W(ID_W), .COORD_W(COORD_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .data_prepare_i(data_prepare),
        .block_width_i(block_width),
        .block_height_i(block_height),
        .data_id_i(data_id),
        .size_type_i(size_type),
        .fetch_req_o(fetch_req),
        .fetch_gnt_i(fetch_gnt),
        .tile_x_o(tile_x),
        .tile_y_o(tile_y),
        .tile_id_o(tile_id),
        .tile_size_o(tile_size),
        .pe_start_o(pe_start),
        .pe_done_i(pe_done),
        .loop_finished_o(loop_finished),
        .busy_o(busy),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int h;
        int id;
        int st;
        int gnt_wait;
        int exp_n;
        int exp_stride;
        int exp_size;
    } vec_t;

    typedef struct {
        int x;
        int y;
        int size;
        int id;
    } tile_t;

    tile_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, longint'(|{fetch_req, tile_x, tile_y, tile_id, tile_size,
                               pe_start, loop_finished, busy, stall_cnt}), 0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        data_prepare = 1'b0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("idle_before_start", busy, 0);
    endtask

    // Runs one pass. hold keeps data_prepare high throughout; abort_at>0
    // pulls reset when the abort_at-th pe_start pulse is observed.
    task automatic run_pass(input vec_t v, input bit hold, input int abort_at);
        int    wn, hn, cyc, starts, reqc, age;
        bit    pend, first, prev_req, done, aborted;
        int    cx, cy;
        tile_t t;
        wn = (v.w == 0) ? 1 : v.w;
        hn = (v.h == 0) ? 1 : v.h;
        for (int r = 0; r < hn; r++)
            for (int c = 0; c < wn; c++)
                exp_q.push_back('{c * v.exp_stride, r * v.exp_stride,
                                  v.exp_size, v.id});
        wait_idle();
        block_width  = BLK_W'(v.w);
        block_height = BLK_W'(v.h);
        data_id      = ID_W'(v.id);
        size_type    = v.st[0];
        data_prepare = 1'b1;
        cyc = 0; starts = 0; reqc = 0; age = 0; cx = 0; cy = 0;
        pend = 0; first = 1; prev_req = 0; done = 0; aborted = 0;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                if (!hold) data_prepare = 1'b0;
                block_width  = '1;
                block_height = '1;
                data_id      = ~data_id;
                size_type    = ~size_type;
            end
            if (fetch_req && !prev_req) begin
                if (first) begin
                    check("first_req_latency", cyc, 1);
                    first = 0;
                end
                if (exp_q.size() == 0) begin
                    check("extra_tile", 1, 0);
                end else begin
                    t = exp_q.pop_front();
                    check("tile_x", tile_x, t.x);
                    check("tile_y", tile_y, t.y);
                    check("tile_size", tile_size, t.size);
                    check("tile_id", tile_id, t.id);
                end
                cx = int'(tile_x);
                cy = int'(tile_y);
                age = 0;
                reqc = 0;
            end
            prev_req = fetch_req;
            if (fetch_req) begin
                reqc++;
                if (age >= v.gnt_wait) begin
                    fetch_gnt = 1'b1;
                    check("coord_stable_x", tile_x, cx);
                    check("coord_stable_y", tile_y, cy);
                end else begin
                    fetch_gnt = 1'b0;
                end
                age++;
            end else begin
                // stray grants outside LOAD must be ignored
                fetch_gnt = (cyc % 2 == 0);
            end
            if (pe_start) begin
                starts++;
                check("req_cycles", reqc, v.gnt_wait + 1);
                // done in the launch cycle must be ignored
                pe_done = 1'b1;
                pend = 1;
                if (abort_at != 0 && starts == abort_at) begin
                    #2 reset_n = 1'b0;
                    #1 check_zero("async_reset_outs");
                    aborted = 1;
                    done = 1;
                end
            end else if (pend) begin
                pe_done = 1'b1;
                pend = 0;
            end else begin
                pe_done = 1'b0;
            end
            if (loop_finished) done = 1;
        end
        fetch_gnt = 1'b0;
        pe_done   = 1'b0;
        if (!done) check("pass_timeout", 0, 1);
        if (aborted) begin
            exp_q.delete();
        end else begin
            check("tiles_left", exp_q.size(), 0);
            check("pe_starts", starts, v.exp_n);
            check("pass_len", cyc, v.exp_n * (v.gnt_wait + 4));
            @(negedge clk);
            check("fin_pulse_width", loop_finished, 0);
            check("busy_in_done", busy, 1);
        end
    endtask

    vec_t vecs[6];
    vec_t v;

    initial begin
        vecs[0] = '{2, 2, 3, 1, 1, 4, 4, 6};
        vecs[1] = '{3, 1, 5, 0, 1, 3, 6, 8};
        vecs[2] = '{2, 1, 1, 1, 5, 2, 4, 6};
        vecs[3] = '{0, 0, 7, 0, 0, 1, 6, 8};
        vecs[4] = '{4, 3, 15, 0, 0, 12, 6, 8};
        vecs[5] = '{1, 255, 9, 0, 0, 255, 6, 8};

        #2 reset_n = 1'b0;
        #1 check_zero("reset_outs");
        repeat (2) @(negedge clk);
        check_zero("reset_hold_outs");
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            run_pass(vecs[i], 1'b0, 0);
            if (i == 2) begin
`ifdef TILE_PERF_CNT_EN
                check("stall_cnt_min", longint'(stall_cnt >= 5), 1);
`else
                check("stall_cnt_tied", stall_cnt, 0);
`endif
            end
        end

        // prepare held after completion: no retrigger
        run_pass(vecs[0], 1'b1, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("done_hold", longint'({busy, fetch_req, pe_start,
                                         loop_finished}), 4'b1000);
        end
        data_prepare = 1'b0;
        @(negedge clk);
        check("done_release", busy, 0);
        v = '{2, 2, 6, 1, 0, 4, 4, 6};
        run_pass(v, 1'b0, 0);

        // reset during COMPUTE of tile 2
        v = '{3, 1, 2, 0, 1, 3, 6, 8};
        run_pass(v, 1'b0, 2);
        data_prepare = 1'b0;
        @(negedge clk);
        check_zero("reset_mid_outs");
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_reset_quiet", longint'({busy, loop_finished}), 0);
        end
        v = '{1, 1, 4, 1, 1, 1, 4, 6};
        run_pass(v, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
